writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have ports: Clk  in  1  single clock, all state on posedge Clk.
REQ-002 SHALL have port: reset  in  1  synchronous, active-low reset, sampled on posedge Clk.
REQ-003 SHALL have ports: mem_valid in 1 MEM-stage result valid; mem_ready out 1 unit can accept.
REQ-004 SHALL have ports: mem_regwrite in 1; mem_memtoreg in 1; mem_rd in 5; mem_alu in 32; mem_rdata in 32.
REQ-005 SHALL have ports: wr_grant in 1, register-file write port available this cycle; flush in 1, discard all buffered results.
REQ-006 SHALL have ports: RegWrite out 1; WriteReg out 5; WriteData out 32, which drive the register-file write port.
REQ-007 SHALL have port: pending out 2, number of buffered writes (0..2).

Function
REQ-008 SHALL accept a result when mem_valid=1 and mem_ready=1 at posedge Clk.
REQ-009 SHALL select the data at acceptance: mem_memtoreg=1 -> mem_rdata, 0 -> mem_alu.
REQ-010 SHALL accept but not enqueue results with mem_regwrite=0 or mem_rd=0, because $zero is never written.
REQ-011 SHALL buffer up to 2 entries {rd[4:0], data[31:0]} in FIFO order, with states EMPTY, ONE, FULL.
REQ-012 SHALL drive mem_ready = (state != FULL), combinationally from state only.
REQ-013 SHALL register RegWrite, WriteReg and WriteData from the head entry: RegWrite=1 iff state != EMPTY; WriteReg/WriteData hold the head values and are 0 when EMPTY.
REQ-014 SHALL give a latency of 1: a result accepted at edge N with an empty buffer and wr_grant=1 appears on RegWrite in cycle N+1.
REQ-015 SHALL pop the head at a posedge where RegWrite=1 and wr_grant=1; with wr_grant=0 the head and outputs SHALL hold unchanged.
REQ-016 SHALL apply these transitions: EMPTY+push -> ONE; ONE+push-pop -> FULL; ONE+pop-push -> EMPTY; ONE+push+pop -> ONE (new entry becomes head); FULL+pop -> ONE; FULL never pushes.
REQ-017 SHALL give flush priority over push and pop: at that edge state -> EMPTY, any concurrent accept is discarded, and RegWrite=0 in the next cycle.
REQ-018 SHALL keep successive entries to the same rd in order, with both written and the last one winning in the register file.
REQ-019 SHALL keep RegWrite/WriteReg/WriteData stable for the whole cycle, because the register file samples them on negedge Clk.

Reset
REQ-020 SHALL, while reset=0 at posedge, set state EMPTY, RegWrite=0, WriteReg=0, WriteData=0, pending=0, mem_ready=1 after the edge.
REQ-021 SHALL drop any in-flight entry on reset mid-operation, with no write issued in the cycle after the reset edge.
REQ-022 SHALL give reset priority over flush, push and pop.

Configuration
REQ-023 SHALL implement macro WB_BYPASS_EN.
REQ-024 SHALL, when WB_BYPASS_EN is defined, add outputs fwd_valid 1, fwd_reg 5, fwd_data 32 = youngest buffered entry (tail), valid iff state != EMPTY, for EX-stage forwarding of not-yet-written results.
REQ-025 SHALL, when WB_BYPASS_EN is undefined, omit the fwd_* ports and logic entirely, with all other behaviour identical.

Structure
REQ-026 SHALL take REG_ADDR_W=5, DATA_W=32, ZERO_REG=5'd0, the state enum {EMPTY, ONE, FULL} and the wb_entry_t struct {rd, data} from shared package mips_pkg.
REQ-027 SHALL place the 2-entry buffer in one sub-module, wb_skid_buffer (push/pop/flush, count, head, tail); writeback_unit holds the select, the $zero filter and the output drive.

Verification
REQ-028 SHALL cover: reset=0 for 2 cycles with mem_valid=1 -> RegWrite=0, pending=0, mem_ready=1 throughout and one cycle after release.
REQ-029 SHALL cover: wr_grant=1, accept rd=8, memtoreg=0, alu=32'h7 -> next cycle RegWrite=1, WriteReg=8, WriteData=32'h7, then RegWrite=0.
REQ-030 SHALL cover: wr_grant=0, accept rd=9 rdata=32'hA (memtoreg=1) then rd=10 alu=32'hB -> mem_ready=0, pending=2; raise wr_grant -> writes 9/A then 10/B on consecutive cycles.
REQ-031 SHALL cover: accept rd=0 regwrite=1 and rd=11 regwrite=0 -> both accepted, pending stays 0, no RegWrite pulse.
REQ-032 SHALL cover: FULL with wr_grant=0, assert flush with mem_valid=1 -> next cycle pending=0, RegWrite=0, and the concurrent input is lost.
REQ-033 SHALL cover, with WB_BYPASS_EN defined: wr_grant=0, accept rd=12 alu=32'h5 -> fwd_valid=1, fwd_reg=12, fwd_data=32'h5 until the pop.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, $zero index, writeback buffer state and entry types
package mips_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} wb_state_t;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/writeback_unit_if.sv
// writeback_unit_if: MEM-stage result handshake into the writeback unit
interface writeback_unit_if;
    import mips_pkg::*;
    logic mem_valid;
    logic mem_ready;
    logic mem_regwrite;
    logic mem_memtoreg;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_alu;
    logic [DATA_W-1:0] mem_rdata;
    modport master (output mem_valid, mem_regwrite, mem_memtoreg, mem_rd, mem_alu, mem_rdata, input mem_ready);
    modport slave (input mem_valid, mem_regwrite, mem_memtoreg, mem_rd, mem_alu, mem_rdata, output mem_ready);
endinterface

// File: rtl/wb_skid_buffer.sv
// wb_skid_buffer: 2-entry FIFO with flush; vacated slots are zeroed (tail port only with WB_BYPASS_EN)
module wb_skid_buffer import mips_pkg::*; (
    input  logic      Clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  wb_entry_t din,
    output logic [1:0] count,
    output wb_entry_t head
`ifdef WB_BYPASS_EN
    , output wb_entry_t tail
`endif
);
    wb_state_t state_q, state_d;
    wb_entry_t e0_q, e0_d, e1_q, e1_d;
    logic do_push, do_pop;
    always_comb begin
        do_push = push && state_q != FULL;
        do_pop = pop && state_q != EMPTY;
        state_d = state_q;
        e0_d = e0_q;
        e1_d = e1_q;
        if (flush) begin
            state_d = EMPTY;
            e0_d = '0;
            e1_d = '0;
        end else begin
            case (state_q)
                EMPTY: if (do_push) begin
                    state_d = ONE;
                    e0_d = din;
                end
                ONE: if (do_push) begin
                    state_d = do_pop ? ONE : FULL;
                    e0_d = do_pop ? din : e0_q;
                    e1_d = do_pop ? '0 : din;
                end else if (do_pop) begin
                    state_d = EMPTY;
                    e0_d = '0;
                end
                FULL: if (do_pop) begin
                    state_d = ONE;
                    e0_d = e1_q;
                    e1_d = '0;
                end
                default: state_d = EMPTY;
            endcase
        end
    end
    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q <= EMPTY;
            e0_q <= '0;
            e1_q <= '0;
        end else begin
            state_q <= state_d;
            e0_q <= e0_d;
            e1_q <= e1_d;
        end
    end
    assign count = state_q;
    assign head = e0_q;
`ifdef WB_BYPASS_EN
    assign tail = state_q == FULL ? e1_q : e0_q;
`endif
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: buffered register-file writeback with $zero filter; WB_BYPASS_EN adds fwd_* tail forwarding
module writeback_unit import mips_pkg::*; (
    input  logic                  Clk,
    input  logic                  reset,
    writeback_unit_if.slave       mem,
    input  logic                  wr_grant,
    input  logic                  flush,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0]     WriteData,
    output logic [1:0]            pending
`ifdef WB_BYPASS_EN
    , output logic                  fwd_valid
    , output logic [REG_ADDR_W-1:0] fwd_reg
    , output logic [DATA_W-1:0]     fwd_data
`endif
);
    wb_entry_t din, head;
    logic push;
`ifdef WB_BYPASS_EN
    wb_entry_t tail;
`endif
    always_comb begin
        din.rd = mem.mem_rd;
        din.data = mem.mem_memtoreg ? mem.mem_rdata : mem.mem_alu;
        push = mem.mem_valid && mem.mem_ready && mem.mem_regwrite && mem.mem_rd != ZERO_REG;
    end
    assign mem.mem_ready = pending != 2'd2;
    wb_skid_buffer u_buf (
        .Clk   (Clk),
        .reset (reset),
        .push  (push),
        .pop   (wr_grant),
        .flush (flush),
        .din   (din),
        .count (pending),
        .head  (head)
`ifdef WB_BYPASS_EN
        , .tail (tail)
`endif
    );
    assign RegWrite = pending != 2'd0;
    assign WriteReg = head.rd;
    assign WriteData = head.data;
`ifdef WB_BYPASS_EN
    assign fwd_valid = pending != 2'd0;
    assign fwd_reg = tail.rd;
    assign fwd_data = tail.data;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: scoreboard bench for writeback_unit (directed cases plus random traffic)
module tb_writeback_unit;
    logic Clk = 1'b0;
    logic reset, wr_grant, flush;
    logic RegWrite;
    logic [4:0] WriteReg;
    logic [31:0] WriteData;
    logic [1:0] pending;
`ifdef WB_BYPASS_EN
    logic fwd_valid;
    logic [4:0] fwd_reg;
    logic [31:0] fwd_data;
`endif
    int total = 0;
    int bad = 0;
    bit chk_en = 0;
    bit m_acc;
    logic [36:0] q[$];
    writeback_unit_if bus();
    writeback_unit dut (
        .Clk       (Clk),
        .reset     (reset),
        .mem       (bus),
        .wr_grant  (wr_grant),
        .flush     (flush),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .pending   (pending)
`ifdef WB_BYPASS_EN
        , .fwd_valid (fwd_valid)
        , .fwd_reg   (fwd_reg)
        , .fwd_data  (fwd_data)
`endif
    );
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [36:0] got, input logic [36:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit v, input bit rw, input bit mt, input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata);
        bus.mem_valid = v;
        bus.mem_regwrite = rw;
        bus.mem_memtoreg = mt;
        bus.mem_rd = rd;
        bus.mem_alu = alu;
        bus.mem_rdata = rdata;
    endtask

    task automatic cyc();
        @(negedge Clk);
    endtask

    always @(posedge Clk) begin
        if (!reset || flush) q.delete();
        else begin
            m_acc = bus.mem_valid && q.size() < 2;
            if (q.size() != 0 && wr_grant) void'(q.pop_front());
            if (m_acc && bus.mem_regwrite && bus.mem_rd != 5'd0)
                q.push_back({bus.mem_rd, bus.mem_memtoreg ? bus.mem_rdata : bus.mem_alu});
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("sb_regwrite", 37'(RegWrite), 37'(q.size() != 0));
            check("sb_pending", 37'(pending), 37'(q.size()));
            check("sb_ready", 37'(bus.mem_ready), 37'(q.size() < 2));
            if (q.size() != 0) check("sb_head", {WriteReg, WriteData}, q[0]);
`ifdef WB_BYPASS_EN
            check("sb_fwd_valid", 37'(fwd_valid), 37'(q.size() != 0));
            if (q.size() != 0) check("sb_fwd", {fwd_reg, fwd_data}, q[q.size()-1]);
`endif
        end
    end

    initial begin
        reset = 1'b0; wr_grant = 1'b1; flush = 1'b0;
        drive(1, 1, 0, 5'd5, 32'h1, 32'h0);
        cyc();
        check("rst_regwrite0", 37'(RegWrite), 37'd0);
        check("rst_pending0", 37'(pending), 37'd0);
        check("rst_ready0", 37'(bus.mem_ready), 37'd1);
        cyc();
        check("rst_regwrite1", 37'(RegWrite), 37'd0);
        check("rst_out1", {WriteReg, WriteData}, 37'd0);
        check("rst_ready1", 37'(bus.mem_ready), 37'd1);
        chk_en = 1;
        reset = 1'b1;
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        cyc();
        check("post_rst_regwrite", 37'(RegWrite), 37'd0);
        check("post_rst_pending", 37'(pending), 37'd0);
        drive(1, 1, 0, 5'd8, 32'h7, 32'h99);
        cyc();
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        check("lat1_regwrite", 37'(RegWrite), 37'd1);
        check("lat1_data", {WriteReg, WriteData}, {5'd8, 32'h7});
        cyc();
        check("lat1_done", 37'(RegWrite), 37'd0);
        wr_grant = 1'b0;
        drive(1, 1, 1, 5'd9, 32'hDEAD, 32'hA);
        cyc();
        drive(1, 1, 0, 5'd10, 32'hB, 32'hBEEF);
        cyc();
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        check("full_ready", 37'(bus.mem_ready), 37'd0);
        check("full_pending", 37'(pending), 37'd2);
        check("full_head", {WriteReg, WriteData}, {5'd9, 32'hA});
        wr_grant = 1'b1;
        cyc();
        check("drain_second", {WriteReg, WriteData}, {5'd10, 32'hB});
        check("drain_pending", 37'(pending), 37'd1);
        cyc();
        check("drain_empty", 37'(RegWrite), 37'd0);
        drive(1, 1, 0, 5'd0, 32'h3, 32'h0);
        cyc();
        check("zero_ready", 37'(bus.mem_ready), 37'd1);
        drive(1, 0, 0, 5'd11, 32'h4, 32'h0);
        cyc();
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        check("filter_pending", 37'(pending), 37'd0);
        check("filter_regwrite", 37'(RegWrite), 37'd0);
        wr_grant = 1'b0;
        drive(1, 1, 0, 5'd13, 32'h13, 32'h0);
        cyc();
        drive(1, 1, 0, 5'd14, 32'h14, 32'h0);
        cyc();
        check("pre_flush_pending", 37'(pending), 37'd2);
        flush = 1'b1;
        drive(1, 1, 0, 5'd15, 32'h15, 32'h0);
        cyc();
        flush = 1'b0;
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        check("flush_full_pending", 37'(pending), 37'd0);
        check("flush_full_regwrite", 37'(RegWrite), 37'd0);
        drive(1, 1, 0, 5'd16, 32'h16, 32'h0);
        cyc();
        flush = 1'b1;
        drive(1, 1, 0, 5'd17, 32'h17, 32'h0);
        cyc();
        flush = 1'b0;
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        check("flush_one_pending", 37'(pending), 37'd0);
        check("flush_one_regwrite", 37'(RegWrite), 37'd0);
        drive(1, 1, 0, 5'd18, 32'h18, 32'h0);
        cyc();
        reset = 1'b0;
        drive(1, 1, 0, 5'd19, 32'h19, 32'h0);
        cyc();
        reset = 1'b1;
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        check("midrst_regwrite", 37'(RegWrite), 37'd0);
        check("midrst_pending", 37'(pending), 37'd0);
`ifdef WB_BYPASS_EN
        drive(1, 1, 0, 5'd12, 32'h5, 32'h0);
        cyc();
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        check("fwd_hit", {fwd_reg, fwd_data}, {5'd12, 32'h5});
        check("fwd_valid1", 37'(fwd_valid), 37'd1);
        cyc();
        check("fwd_hold", {fwd_reg, fwd_data}, {5'd12, 32'h5});
        wr_grant = 1'b1;
        cyc();
        check("fwd_valid0", 37'(fwd_valid), 37'd0);
`endif
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), $urandom, $urandom);
            wr_grant = 1'($urandom_range(0, 1));
            flush = $urandom_range(0, 15) == 0;
            reset = $urandom_range(0, 31) != 0;
            cyc();
        end
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        wr_grant = 1'b1; flush = 1'b0; reset = 1'b1;
        repeat (3) cyc();
        check("final_pending", 37'(pending), 37'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
